mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single backing datamem between two requesters: data-cache miss/bypass port (D) and
//  instruction-fetch refill port (I). Round-robin grant, one transaction at a time, fixed memory
//  latency sequenced by a counter. Sits between the cache instances and datamem, driving the datamem port.
// PARAMETERS
//  DATA_WIDTH   32  data bus width
//  ADDR_WIDTH   32  address width
//  MEM_LATENCY  2   cycles mem_* held stable per access, >=1; write pulse in last cycle
//  ROUND_ROBIN  1   1: alternating priority on conflict; 0: D always wins
// PORTS
//  clk              in   1    clock, rising edge
//  rst              in   1    asynchronous, active-low reset
//  d_req / i_req    in   1    request; held with fields stable until own *_rvalid
//  d_we / i_we      in   1    write request (I port: tie 0, still honoured)
//  d_type / i_type  in   2    type_control (00 word, 01 half, 10 byte)
//  d_sign_ext/i_..  in   1    sign-extend sub-word reads
//  d_addr / i_addr  in   AW   byte address
//  d_wdata/i_wdata  in   DW   write data
//  d_gnt / i_gnt    out  1    high while that port owns memory (BUSY and DONE)
//  d_rvalid/i_rvalid out 1    one-cycle completion pulse, reads and writes
//  d_rdata/i_rdata  out  DW   captured read data, valid with rvalid, held until next completion
//  mem_write_en     out  1    to datamem
//  mem_type_control out  2    to datamem
//  mem_addr         out  AW   to datamem
//  mem_din          out  DW   to datamem
//  mem_sign_ext     out  1    to datamem
//  mem_dout         in   DW   datamem read data (combinational read)
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE, cnt 0, owner D, last-winner D (next conflict goes to I when
//   ROUND_ROBIN=1, else D), all outputs 0, *_rdata 0. Takes effect immediately, mid-access too:
//   mem_write_en drops at once, no rvalid issued, no partial write beyond the cycle already elapsed.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: at clock edge with any req: latch winner's we/type/sign_ext/addr/wdata into regs,
//     set owner, cnt<=MEM_LATENCY-1, go BUSY. No req: stay.
//     Conflict: ROUND_ROBIN=1 -> port that did not win last conflict-or-grant; 0 -> D.
//   BUSY: mem_* driven from latched regs only (input changes ignored). mem_write_en = latched we
//     && cnt==0. cnt decrements; at cnt==0 capture mem_dout into owner's rdata (reads only;
//     writes leave rdata unchanged), go DONE.
//   DONE: owner's rvalid=1 for exactly this cycle; mem_write_en=0; no new grant this cycle
//     (requester drops/changes req on this edge). Next edge -> IDLE.
//  Latency: req seen at edge N -> BUSY cycles N+1..N+MEM_LATENCY -> rvalid at N+MEM_LATENCY+1.
//   Back-to-back throughput: one access per MEM_LATENCY+2 cycles.
//  Outside BUSY: mem_* = 0 (address/data zero, write_en 0).
//  last-winner updates on every grant; non-owner gnt/rvalid stay 0 throughout.
//  Withdrawn req during BUSY: access still completes, rvalid still issued (no abort).
//  Width: cnt is $clog2(MEM_LATENCY+1) bits; MEM_LATENCY=1 -> single BUSY cycle.
//  Assertions: at most one gnt; rvalid only in DONE; mem_write_en never for >1 cycle per access.
// STRUCTURE
//  mem_pkg: typedef enum {IDLE,BUSY,DONE} arb_state_t; typedef enum logic {PORT_D,PORT_I} port_t;
//   type_control constants TC_WORD/TC_HALF/TC_BYTE; struct mem_req_t {we,type,sign_ext,addr,wdata}.
//  One sub-module: rr_pick2 (combinational 2-way priority pick from reqs + last-winner).
//  Counter, FSM, request latch, rdata regs in mem_arbiter.
// TESTING (MEM_LATENCY=2 unless noted)
//  1 Single D read: datamem[0x100]=0xDEADBEEF, d_req word addr 0x100 at edge 0 -> d_gnt cycles 1-3,
//    d_rvalid cycle 3 only, d_rdata=0xDEADBEEF, i_* stay 0.
//  2 Conflict: both req at edge 0 after reset (D wr 0x200<-0x12345678, I rd 0x0) -> I served first
//    (rvalid cycle 3), then D (rvalid cycle 7); mem_write_en high only cycle 6; readback 0x12345678.
//  3 Round-robin: both hold req continuously for 4 accesses -> grants alternate I,D,I,D;
//    ROUND_ROBIN=0 -> D,D,D,D while D holds req.
//  4 Byte/half: D write byte 0xAB to 0x203, read signed byte 0x203 -> 0xFFFFFFAB, unsigned
//    -> 0x000000AB; mem_type_control=10 held through BUSY.
//  5 Reset mid-write: D write to 0x300, rst=0 in first BUSY cycle -> outputs 0 asynchronously,
//    mem[0x300] unchanged, no rvalid; after release fresh request completes normally.
//  6 Input stability: change d_addr during BUSY -> mem_addr stays latched value; MEM_LATENCY=1
//    run of test 1 -> rvalid at cycle 2.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the datamem arbiter
package mem_arbiter_pkg;
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    localparam logic [1:0] TC_WORD = 2'b00;
    localparam logic [1:0] TC_HALF = 2'b01;
    localparam logic [1:0] TC_BYTE = 2'b10;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    typedef enum logic {PORT_D, PORT_I} port_t;
    typedef struct packed {
        logic              we;
        logic [1:0]        tc;
        logic              sign_ext;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;
    function automatic port_t other_port(input port_t p);
        return p == PORT_D ? PORT_I : PORT_D;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way pick from requests and the last winner
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic d_req,
    input  logic i_req,
    input  logic last,
    output logic pick
);
    assign pick = (d_req && i_req) ? (ROUND_ROBIN != 0 ? other_port(port_t'(last)) : PORT_D)
                                   : (i_req ? PORT_I : PORT_D);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one datamem between the D and I ports, one fixed-latency access at a time
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = MEM_DW,
    parameter int ADDR_WIDTH  = MEM_AW,
    parameter int MEM_LATENCY = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_type,
    input  logic                  d_sign_ext,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_type,
    input  logic                  i_sign_ext,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  mem_write_en,
    output logic [1:0]            mem_type_control,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_sign_ext,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
    arb_state_t     state;
    port_t          owner;
    port_t          last;
    logic [CW-1:0]  cnt;
    mem_req_t       req_q;
    mem_req_t       d_in;
    mem_req_t       i_in;
    logic           pick;
    logic           busy;
    assign d_in = '{we: d_we, tc: d_type, sign_ext: d_sign_ext, addr: d_addr, wdata: d_wdata};
    assign i_in = '{we: i_we, tc: i_type, sign_ext: i_sign_ext, addr: i_addr, wdata: i_wdata};
    rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .d_req(d_req),
        .i_req(i_req),
        .last (last),
        .pick (pick)
    );
    // memory side sees only the latched request, and only while an access is in flight
    assign busy             = state == BUSY;
    assign mem_type_control = busy ? req_q.tc : 2'b00;
    assign mem_addr         = busy ? req_q.addr : '0;
    assign mem_din          = busy ? req_q.wdata : '0;
    assign mem_sign_ext     = busy && req_q.sign_ext;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= PORT_D;
            last         <= PORT_D;
            req_q        <= '0;
            d_gnt        <= 1'b0;
            i_gnt        <= 1'b0;
            d_rvalid     <= 1'b0;
            i_rvalid     <= 1'b0;
            mem_write_en <= 1'b0;
            d_rdata      <= '0;
            i_rdata      <= '0;
        end else begin
            case (state)
                IDLE: if (d_req || i_req) begin
                    owner        <= port_t'(pick);
                    last         <= port_t'(pick);
                    req_q        <= pick ? i_in : d_in;
                    cnt          <= CNT_INIT;
                    d_gnt        <= !pick;
                    i_gnt        <= pick;
                    mem_write_en <= (pick ? i_we : d_we) && MEM_LATENCY == 1;
                    state        <= BUSY;
                end
                BUSY: begin
                    cnt          <= cnt - 1'b1;
                    // write strobe lands in the final BUSY cycle only
                    mem_write_en <= req_q.we && cnt == CW'(1);
                    if (cnt == '0) begin
                        if (!req_q.we && owner == PORT_D) d_rdata <= mem_dout;
                        if (!req_q.we && owner == PORT_I) i_rdata <= mem_dout;
                        d_rvalid <= owner == PORT_D;
                        i_rvalid <= owner == PORT_I;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    d_gnt    <= 1'b0;
                    i_gnt    <= 1'b0;
                    d_rvalid <= 1'b0;
                    i_rvalid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(d_gnt && i_gnt));
    a_rvalid_done: assert property (@(posedge clk) disable iff (!rst_n) (d_rvalid || i_rvalid) |-> state == DONE);
    a_we_pulse: assert property (@(posedge clk) disable iff (!rst_n) mem_write_en |=> !mem_write_en);
endmodule
